// File: rtl/arb4_rr_pkg.sv
// Shared definitions for round-robin arbiters: requester count and FSM state encoding.
package arb4_rr_pkg;
    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;
endpackage

// File: rtl/arb4_rr_pick.sv
// Round-robin pick: first set request scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
// Purely combinational; the requester at ptr gets lowest priority.
module rr_pick4
    import arb4_rr_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [1:0]       idx_o,
    output logic             vld_o
);
    logic [1:0] cand;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        vld_o  = 1'b0;
        cand   = '0;
        // Walk from lowest to highest priority so the closest set bit after ptr wins.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ptr_i + 2'(k);
            if (req_i[cand]) begin
                pick_o = 4'b0001 << cand;
                idx_o  = cand;
                vld_o  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arb4_rr.sv
// Four-way round-robin arbiter owning the shared-resource mux select.
// Grant appears one cycle after request; held until i_done, owner abandon or hold timeout.
module arb4_rr
    import arb4_rr_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_done,
    output logic [N_REQ-1:0] o_gnt,
    output logic [1:0]       o_sel,
    output logic             o_busy,
    output logic             o_timeout
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [1:0]       sel_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    logic [N_REQ-1:0] pick;
    logic [1:0]       pick_idx;
    logic             pick_vld;
    logic             owner_req;
    logic             hold_expired;

    // ptr_q is the current owner while granted, so one picker serves both idle and handoff.
    rr_pick4 u_pick (
        .req_i  (i_req),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    assign owner_req    = i_req[ptr_q];
    assign hold_expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= 2'd3;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == ST_IDLE || i_done) begin
                // i_done is ignored when idle; on release with any request pending, hand off directly.
                if (pick_vld) begin
                    state_q <= ST_GRANT;
                    gnt_q   <= pick;
                    sel_q   <= pick_idx;
                    ptr_q   <= pick_idx;
                    cnt_q   <= '0;
                end else begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            end else if (!owner_req) begin
                state_q <= ST_IDLE;
                gnt_q   <= '0;
            end else if (hold_expired) begin
                state_q   <= ST_IDLE;
                gnt_q     <= '0;
                timeout_q <= 1'b1;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_gnt     = gnt_q;
    assign o_sel     = sel_q;
    assign o_busy    = |gnt_q;
    assign o_timeout = timeout_q;
endmodule

// File: tb/tb_arb4_rr.sv
// Bench for arb4_rr (TIMEOUT=8): directed vector table, reset sequence, randomized run vs model.
module tb_arb4_rr;
    localparam int TO = 8;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [3:0] i_req = '0;
    logic       i_done = 1'b0;
    logic [3:0] o_gnt;
    logic [1:0] o_sel;
    logic       o_busy;
    logic       o_timeout;

    arb4_rr #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_done    (i_done),
        .o_gnt     (o_gnt),
        .o_sel     (o_sel),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       to;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    // Reference model state: owner index (-1 = idle), last owner, cycles held.
    int   m_owner;
    int   m_last;
    int   m_cnt;
    int   m_sel;
    bit   m_to;

    function automatic void add(input logic [3:0] r, input logic d, input logic [3:0] g,
                                input logic [1:0] s, input logic t);
        vec_t v;
        v.req = r; v.done = d; v.gnt = g; v.sel = s; v.to = t;
        tbl.push_back(v);
    endfunction

    function automatic int pickf(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_last = 3; m_cnt = 0; m_sel = 0; m_to = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic d);
        int w;
        m_to = 0;
        if (m_owner < 0 || d) begin
            w = pickf(r, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_cnt = 0; m_sel = w;
            end else begin
                m_owner = -1;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_cnt == TO - 1) begin
            m_owner = -1;
            m_to = 1;
        end else begin
            m_cnt++;
        end
    endfunction

    task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] es, input logic et);
        nvec++;
        if (o_gnt !== eg || o_sel !== es || o_busy !== (|eg) || o_timeout !== et) begin
            nerr++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b to=%b, expected gnt=%b sel=%0d busy=%b to=%b",
                     nm, o_gnt, o_sel, o_busy, o_timeout, eg, es, |eg, et);
        end
    endtask

    task automatic apply(input logic [3:0] r, input logic d);
        i_req  = r;
        i_done = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_req  = '0;
        i_done = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Directed table (inputs applied, outputs expected after the next edge).
        add(4'b0001, 0, 4'b0001, 2'd0, 0);                 // first grant goes to 0
        add(4'b1111, 0, 4'b0001, 2'd0, 0);
        add(4'b1111, 1, 4'b0010, 2'd1, 0);                 // back-to-back handoff
        add(4'b1111, 0, 4'b0010, 2'd1, 0);
        add(4'b1111, 0, 4'b0010, 2'd1, 0);
        add(4'b1111, 1, 4'b0100, 2'd2, 0);
        add(4'b1111, 0, 4'b0100, 2'd2, 0);
        add(4'b1111, 0, 4'b0100, 2'd2, 0);
        add(4'b1100, 1, 4'b1000, 2'd3, 0);                 // owner 2 done, 2 still asks: 3 wins
        add(4'b1111, 0, 4'b1000, 2'd3, 0);
        add(4'b1111, 1, 4'b0001, 2'd0, 0);                 // wrap to 0
        add(4'b1111, 1, 4'b0010, 2'd1, 0);
        add(4'b1100, 0, 4'b0000, 2'd1, 0);                 // owner 1 abandons, sel holds
        add(4'b0100, 0, 4'b0100, 2'd2, 0);
        add(4'b0010, 1, 4'b0010, 2'd1, 0);                 // owner 1 granted, never done
        for (int i = 0; i < TO - 1; i++) add(4'b0010, 0, 4'b0010, 2'd1, 0);
        add(4'b0010, 0, 4'b0000, 2'd1, 1);                 // forced release with pulse
        add(4'b0011, 0, 4'b0001, 2'd0, 0);                 // pulse gone, 1 deprioritised
        for (int i = 0; i < TO - 1; i++) add(4'b0001, 0, 4'b0001, 2'd0, 0);
        add(4'b0001, 1, 4'b0001, 2'd0, 0);                 // done at timeout edge: regrant, no pulse
        add(4'b0000, 0, 4'b0000, 2'd0, 0);                 // abandon
        add(4'b0000, 1, 4'b0000, 2'd0, 0);                 // done while idle ignored

        i_rst = 1'b1;
        #12;
        check("reset_state", 4'b0000, 2'd0, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].req, tbl[i].done);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].to);
        end

        // Asynchronous reset in the middle of a grant.
        apply(4'b0100, 0);
        check("pre_async_rst", 4'b0100, 2'd2, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("async_rst", 4'b0000, 2'd0, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        apply(4'b1000, 0);
        check("post_rst_grant3", 4'b1000, 2'd3, 1'b0);

        // Randomized run against the behavioural model.
        do_reset();
        #1;
        check("rand_reset", 4'b0000, 2'd0, 1'b0);
        begin
            logic [3:0] r;
            logic       d;
            r = '0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                if (i < 1000) d = ($urandom_range(0, 3) == 0);
                else          d = ($urandom_range(0, 13) == 0);
                apply(r, d);
                model_step(r, d);
                check($sformatf("rand%0d", i), (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner),
                      2'(m_sel), m_to);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/arb4_rr.md
Name: arb4_rr

Overview:
- Round-robin arbiter sharing one 4:1-muxed resource (e.g. memory/bus port) between four requesters.
- Owns the mux select: issues a one-hot grant plus the matching 2-bit select, and holds the grant until the resource signals completion.
- Supports back-to-back handoff, owner-abandon release and an optional hang timeout.
- Sits beside the mux4 that carries requester address/data into the shared resource.

Parameters:
- TIMEOUT, 0, max cycles a grant may be held without i_done before forced release; 0 disables the timeout.
- CNT_W, 16, width of the hold counter; TIMEOUT must be < 2**CNT_W.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req  input  4  per-requester request level; held high until served.
- i_done  input  1  resource completed the current owner's transaction (1-cycle pulse).
- o_gnt  output  4  one-hot grant, registered; all-zero when idle.
- o_sel  output  2  binary index of the granted requester, drives the mux4 select.
- o_busy  output  1  high while any grant is held (equals |o_gnt).
- o_timeout  output  1  one-cycle pulse when a grant is force-released by timeout.

Behaviour:
- Reset (async, active-high): o_gnt=0, o_sel=0, o_busy=0, o_timeout=0, state=IDLE, last-owner pointer ptr=3 (so requester 0 wins first), hold counter=0.
- States: IDLE, GRANT.
- Pick function: the first set bit of i_req scanning ptr+1, ptr+2, ptr+3, ptr (mod 4), so the last owner gets lowest priority.
- IDLE:
  - If i_req != 0, register the pick: o_gnt/o_sel/o_busy update next edge, ptr <= winner, counter <= 0, go to GRANT.
  - Latency is request seen at edge N, grant visible after edge N+1 (1 cycle).
- GRANT, evaluated each cycle, highest priority first:
  1. i_done=1: release. If any i_req bit other than the owner's is set, or the owner's is still set, perform the pick with ptr=owner and grant the winner at the next edge (direct handoff, no bubble). Otherwise clear o_gnt and go to IDLE.
  2. Owner's i_req=0 without i_done (abandon): clear o_gnt and go to IDLE; no handoff this cycle.
  3. TIMEOUT!=0 and counter==TIMEOUT-1: clear o_gnt, pulse o_timeout for 1 cycle, go to IDLE; ptr stays as the owner so the owner gets lowest priority next.
  4. Else hold the grant and increment the counter (saturating at all-ones).
- o_sel keeps its last value while idle so the mux output never goes undefined. o_sel only changes on the same edge as a new grant.
- o_gnt is always one-hot or zero; a grant never changes owner mid-transaction except via rule 1 or 3.
- Simultaneous i_done and timeout: i_done wins and no o_timeout pulse is generated.
- i_done while IDLE is ignored.
- Single requester holding i_req across i_done is re-granted immediately (ptr wraps back to itself).
- Reset mid-GRANT: o_gnt drops asynchronously, with no o_timeout pulse.

Decomposition:
- Shared header gets the state encodings (ST_IDLE=1'b0, ST_GRANT=1'b1) and requester count N_REQ=4, reused by future arbiters.
- One natural combinational sub-module: rr_pick4. Inputs are req[3:0] and ptr[1:0]; outputs are a one-hot pick[3:0], an index idx[1:0] and a valid flag.

Test Plan:
- Reset then i_req=4'b0001 → o_gnt=0001 and o_sel=0 one cycle later; o_busy=1.
- All four request continuously, i_done pulsed every 3rd cycle → grant order 0,1,2,3,0 with no idle cycle between owners.
- Owner 2 granted, i_req=4'b1100 and i_done same cycle → next grant 3 (o_sel=3), not 2.
- TIMEOUT=8, owner 1 never sees i_done → after 8 grant cycles o_gnt=0 and o_timeout pulses once. Then with i_req=4'b0011 the next grant is 0.
- Owner drops i_req with no i_done → o_gnt=0 next cycle, o_sel holds the old value; i_done in same cycle as timeout → no o_timeout.
- Assert i_rst mid-grant → o_gnt=0 immediately (async). After release, i_req=4'b1000 → grant 3.
